// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receiver
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - PS/2 pin, enable and received-byte bundle
interface ps2_rx_if
  import ps2_pkg::*;
();

  logic                 ps2c;
  logic                 ps2d;
  logic                 rx_en;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done_tick;

  // Drives the PS/2 lines and enable, consumes received bytes
  modport master (
    output ps2c,
    output ps2d,
    output rx_en,
    input  dout,
    input  rx_done_tick
  );

  // The receiver itself
  modport slave (
    input  ps2c,
    input  ps2d,
    input  rx_en,
    output dout,
    output rx_done_tick
  );

endinterface

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - PS/2 line synchronizer, clock deglitcher and fall strobe
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall_edge
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt;
  logic [FILTER_LEN-1:0] filt_next;
  logic                  f_ps2c;
  logic                  f_next;

  // Two-flop synchronizers; reset to the idle (high) bus level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
    end
  end

  // Next filter contents and level: change only on a full run of equal samples
  always_comb begin
    filt_next = {filt[FILTER_LEN-2:0], c_sync[1]};
    f_next    = f_ps2c;
    if (&filt_next) begin
      f_next = 1'b1;
    end else if (~|filt_next) begin
      f_next = 1'b0;
    end
  end

  // Filter register, filtered level and a one-cycle strobe on its 1->0 change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt      <= '1;
      f_ps2c    <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      filt      <= filt_next;
      f_ps2c    <= f_next;
      fall_edge <= f_ps2c & ~f_next;
    end
  end

  assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic     clk,
  input  logic     reset,
  ps2_rx_if.slave  bus
);

  logic                  fall_edge;
  logic                  ps2d_sync;
  state_t                state;
  logic [FRAME_BITS-1:0] b;
  logic [CNT_W-1:0]      n;
  logic                  tick;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (bus.ps2c),
    .ps2d      (bus.ps2d),
    .ps2d_sync (ps2d_sync),
    .fall_edge (fall_edge)
  );

  // Frame FSM: enable gates only the start bit; a started frame always runs to the end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      b     <= '0;
      n     <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_edge && bus.rx_en) begin
            b     <= {ps2d_sync, b[FRAME_BITS-1:1]};
            n     <= CNT_W'(FRAME_BITS - 2);
            state <= DPS;
          end
        end
        DPS: begin
          if (fall_edge) begin
            b <= {ps2d_sync, b[FRAME_BITS-1:1]};
            if (n == '0) begin
              state <= LOAD;
              tick  <= 1'b1;
            end else begin
              n <= n - 1'b1;
            end
          end
        end
        LOAD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout         = b[DATA_BITS:1];
  assign bus.rx_done_tick = tick;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - scoreboard bench for ps2_rx
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int F    = 8;
  localparam int HALF = 250;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  ps2_rx_if bus();

  ps2_rx #(.FILTER_LEN(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int ticks = 0;
  int edges = 0;
  logic prev_tick = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (dut.u_filter.fall_edge === 1'b1) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_clks(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input int nbits,
                            input bit drop_en, input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = fr[i];
      if (glitch) begin
        wait_clks(100);
        bus.ps2c = 1'b0;
        wait_clks(5);
        bus.ps2c = 1'b1;
        wait_clks(HALF - 105);
      end else begin
        wait_clks(HALF);
      end
      bus.ps2c = 1'b0;
      if (i == 10) last_fall_cyc = cyc;
      wait_clks(HALF);
      if (drop_en && i == 0) bus.rx_en = 1'b0;
      bus.ps2c = 1'b1;
    end
    bus.ps2d = 1'b1;
  endtask

  // Monitor: pop the expected byte whenever the DUT reports one
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.rx_done_tick === 1'b1) begin
        ticks++;
        if (prev_tick === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL tick_width: tick high %0d consecutive cycles, required 1", 2);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: dout %0h with no byte expected", bus.dout);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("dout_at_tick", 32'(bus.dout), 32'(e));
          checks++;
          if (cyc - last_fall_cyc > F + 4) begin
            errors++;
            $display("FAIL tick_latency: %0d clocks after last fall, required <= %0d",
                     cyc - last_fall_cyc, F + 4);
          end
        end
      end
      prev_tick = bus.rx_done_tick;
    end
  end

  initial begin
    reset      = 1'b1;
    bus.ps2c   = 1'b1;
    bus.ps2d   = 1'b1;
    bus.rx_en  = 1'b0;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(50);

    // Reset state
    check("reset_dout", 32'(bus.dout), 32'h00);
    check("reset_tick", 32'(bus.rx_done_tick), 32'h0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    check("reset_edges", 32'(edges), 32'd0);

    // 0x45 with deliberately wrong parity bit 1
    bus.rx_en = 1'b1;
    exp_q.push_back(8'h45);
    send_frame(8'h45, 1'b1, 11, 1'b0, 1'b0);
    wait_clks(300);
    check("ticks_after_45", 32'(ticks), 32'd1);
    check("edges_after_45", 32'(edges), 32'd11);

    // Same frame with rx_en low is ignored
    bus.rx_en = 1'b0;
    send_frame(8'h45, 1'b1, 11, 1'b0, 1'b0);
    wait_clks(300);
    check("ticks_rx_en_low", 32'(ticks), 32'd1);
    check("dout_rx_en_low", 32'(bus.dout), 32'h45);

    // rx_en dropped after the start bit: frame still completes
    bus.rx_en = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 11, 1'b1, 1'b0);
    wait_clks(300);
    check("ticks_after_a5", 32'(ticks), 32'd2);
    bus.rx_en = 1'b1;

    // Short low glitches between real edges
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b1);
    wait_clks(300);
    check("ticks_after_1c", 32'(ticks), 32'd3);
    check("dout_after_1c", 32'(bus.dout), 32'h1C);

    // Reset after 5 bits, then a clean 0xF0 frame
    send_frame(8'hFF, 1'b0, 5, 1'b0, 1'b0);
    wait_clks(300);
    reset = 1'b1;
    wait_clks(3);
    check("midreset_dout", 32'(bus.dout), 32'h00);
    check("midreset_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    wait_clks(50);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 11, 1'b0, 1'b0);
    wait_clks(300);
    check("ticks_after_f0", 32'(ticks), 32'd4);

    // Back-to-back 0xE0, 0x75 with dout held in between
    exp_q.push_back(8'hE0);
    send_frame(8'hE0, 1'b0, 11, 1'b0, 1'b0);
    wait_clks(300);
    check("ticks_after_e0", 32'(ticks), 32'd5);
    wait_clks(1000);
    check("dout_hold_e0", 32'(bus.dout), 32'hE0);
    exp_q.push_back(8'h75);
    send_frame(8'h75, 1'b0, 11, 1'b0, 1'b0);
    wait_clks(300);
    check("ticks_after_75", 32'(ticks), 32'd6);
    check("dout_after_75", 32'(bus.dout), 32'h75);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host serial receiver (keyboard/mouse side of the host interface).
- Samples the open-collector PS/2 clock and data lines in the system clock domain and deglitches the PS/2 clock.
- On each filtered falling edge, shifts in one 11-bit frame: start, 8 data bits LSB-first, parity, stop.
- Presents the data byte with a one-cycle done tick to downstream scan-code logic.

Parameters:
- FILTER_LEN, 8, number of consecutive identical system-clock samples of ps2c needed to change the filtered clock level (range 2..16).

Ports:
- clk  input  1  system clock (50 MHz nominal; PS/2 clock is 10–16.7 kHz).
- reset  input  1  asynchronous, active-high reset.
- ps2d  input  1  PS/2 data line, asynchronous.
- ps2c  input  1  PS/2 clock line, asynchronous.
- rx_en  input  1  receive enable; a new frame can start only while high.
- dout  output  8  last received data byte.
- rx_done_tick  output  1  one-clock pulse when dout holds a new byte.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high.
- Synchronizer: ps2c and ps2d each pass through a 2-flop synchronizer. Reset value of each flop is 1 (idle bus).
- Filter:
  - A FILTER_LEN-bit shift register takes the synchronized ps2c each cycle; reset value is all ones.
  - Filtered clock f_ps2c goes to 1 when the register is all ones, goes to 0 when it is all zeros, and otherwise holds.
  - f_ps2c resets to 1.
  - fall_edge is a single-cycle strobe when f_ps2c goes from 1 to 0.
  - Worst-case detection latency after the pin falls: 2 + FILTER_LEN clocks.
- Data is sampled from the synchronized ps2d in the same cycle as fall_edge.
- FSM states (reset state IDLE):
  - IDLE: if fall_edge && rx_en, shift the sampled bit into an 11-bit frame register b (shift right, new bit enters at b[10]), load bit counter n = 9, and go to DPS. Otherwise stay. A fall_edge while rx_en is low is ignored.
  - DPS: on each fall_edge, shift in the bit. If n == 0, go to LOAD; otherwise n <= n-1. rx_en is not checked mid-frame; once started, a frame always completes.
  - LOAD: assert rx_done_tick for exactly this one cycle, then return to IDLE.
- After 11 bits, b[0] is the start bit, b[8:1] the data, b[9] the parity and b[10] the stop bit.
- dout = b[8:1], continuously driven from the frame register; valid when rx_done_tick is high and stable until the next frame starts shifting.
- Error handling:
  - Start, parity and stop bits are not checked.
  - A byte with wrong parity or framing is still delivered with rx_done_tick.
- Reset values: b = 0, n = 0, dout = 0x00, rx_done_tick = 0.
- Reset mid-frame aborts the frame immediately; the next edge is treated as a new start bit.
- No timeout. A truncated frame stalls in DPS until further edges arrive or reset is applied.
- Glitches on ps2c shorter than FILTER_LEN clocks produce no edge.

Decomposition:
- Shared package ps2_pkg: state enum {IDLE, DPS, LOAD}, FRAME_BITS = 11, DATA_BITS = 8.
- One natural sub-module, ps2_clk_filter: synchronizer, FILTER_LEN deglitch filter and fall-edge strobe. It also outputs the synchronized ps2d.

Test Plan:
1. Reset pulse with ps2c = ps2d = 1 → dout = 0x00, rx_done_tick = 0, no edges detected, FSM in IDLE.
2. ps2c at 5 µs half-period, rx_en = 1, frame bits 0,1,0,1,0,0,0,1,0,1,1 (byte 0x45, parity bit 1 even though odd parity requires 0, stop 1) → exactly one rx_done_tick, dout = 0x45, asserted within 2 + FILTER_LEN + 2 clocks after the 11th ps2c fall.
3. Same frame sent with rx_en = 0 → no rx_done_tick, dout unchanged. Then drop rx_en low after the start bit of a 0xA5 frame → 0xA5 still delivered.
4. Inject 5-clock low glitches on ps2c between real edges of a 0x1C frame → dout = 0x1C, exactly one tick.
5. Assert reset after 5 bits of a frame, then send a full 0xF0 frame → dout = 0xF0, one tick, no stale bits.
6. Two back-to-back frames 0xE0 then 0x75 → two ticks, dout = 0xE0 then 0x75, dout stable between the ticks.
